// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared FSM state and mode constants for the vote tally block
package vote_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_WAIT_RELEASE
  } state_t;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/tally_argmax.sv
// rtl/tally_argmax.sv - combinational argmax over candidate tallies with tie detection
module tally_argmax #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = $clog2(NUM_CAND)
) (
  input  logic [NUM_CAND-1:0][CNT_W-1:0] tallies,
  output logic [IDX_W-1:0]               max_idx,
  output logic                           tie
);

  logic [CNT_W-1:0] best;

  // Strict '>' keeps the lowest index on equal maxima; tie restarts on every new maximum.
  always_comb begin
    best    = tallies[0];
    max_idx = '0;
    tie     = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (tallies[i] > best) begin
        best    = tallies[i];
        max_idx = IDX_W'(i);
        tie     = 1'b0;
      end else if (tallies[i] == best) begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_tally_n.sv
// rtl/vote_tally_n.sv - debounced N-candidate vote counter with result display and winner
module vote_tally_n
  import vote_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 10,
  localparam int IDX_W   = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] button,
  output logic [CNT_W-1:0]    led,
  output logic                vote_valid,
  output logic [IDX_W-1:0]    winner,
  output logic                tie,
  output logic                overflow
);

  localparam logic [NUM_CAND-1:0] ONE = {{(NUM_CAND-1){1'b0}}, 1'b1};

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              sel_q, sel_d;
  logic [HOLD_W-1:0]             hold_q, hold_d;
  logic [NUM_CAND-1:0][CNT_W-1:0] tally_q;
  logic                          accept;

  logic [IDX_W-1:0]    low_idx;
  logic                onehot;
  logic [NUM_CAND-1:0] sel_mask;
  logic [HOLD_W:0]     hold_next;
  logic [IDX_W-1:0]    am_idx;
  logic                am_tie;

  assign onehot    = (button != '0) && ((button & (button - ONE)) == '0);
  assign sel_mask  = ONE << sel_q;
  assign hold_next = {1'b0, hold_q} + (HOLD_W+1)'(1);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (button[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode == MODE_VOTE && button != '0) begin
          if (onehot) begin
            state_d = S_DEBOUNCE;
            sel_d   = low_idx;
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = S_WAIT_RELEASE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (button == '0) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (mode == MODE_VOTE && button == sel_mask) begin
          // hold_next counts the cycle being sampled now, so DEBOUNCE stable cycles total
          if (hold_next >= (HOLD_W+1)'(DEBOUNCE)) begin
            state_d = S_ACCEPT;
            hold_d  = '0;
          end else begin
            hold_d = hold_next[HOLD_W-1:0];
          end
        end else begin
          state_d = S_WAIT_RELEASE;
          hold_d  = '0;
        end
      end
      S_ACCEPT: begin
        accept  = 1'b1;
        state_d = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (button == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  tally_argmax #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W)
  ) u_argmax (
    .tallies (tally_q),
    .max_idx (am_idx),
    .tie     (am_tie)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      hold_q     <= '0;
      tally_q    <= '0;
      led        <= '0;
      vote_valid <= 1'b0;
      winner     <= '0;
      tie        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      vote_valid <= accept;
      winner     <= am_idx;
      tie        <= am_tie;
      if (accept) begin
        if (tally_q[sel_q] == '1) overflow <= 1'b1;
        else tally_q[sel_q] <= tally_q[sel_q] + CNT_W'(1);
      end
      if (mode == MODE_RESULT && button != '0) led <= tally_q[low_idx];
      else led <= '0;
    end
  end

endmodule

// File: tb/tb_vote_tally_n.sv
// tb/tb_vote_tally_n.sv - scoreboard bench for vote_tally_n, default and 2-bit counter instances
module tb_vote_tally_n;

  localparam int DEB = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] button = 4'b0000;

  logic [7:0] led_a;
  logic       vv_a, tie_a, ovf_a;
  logic [1:0] win_a;
  logic [1:0] led_s;
  logic       vv_s, tie_s, ovf_s;
  logic [1:0] win_s;

  vote_tally_n dut (
    .clock(clock), .reset(reset), .mode(mode), .button(button),
    .led(led_a), .vote_valid(vv_a), .winner(win_a), .tie(tie_a), .overflow(ovf_a)
  );

  vote_tally_n #(.NUM_CAND(4), .CNT_W(2), .DEBOUNCE(DEB)) dut_s (
    .clock(clock), .reset(reset), .mode(mode), .button(button),
    .led(led_s), .vote_valid(vv_s), .winner(win_s), .tie(tie_s), .overflow(ovf_s)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int fails  = 0;

  typedef struct { int at; int idx; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int  tal[4];
  int  tal_s[4];
  bit  m_ovf, m_ovf_s;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic void argmax(input int t[4], output int w, output int ti);
    int m = -1;
    int n = 0;
    w = 0;
    for (int i = 0; i < 4; i++) if (t[i] > m) begin m = t[i]; w = i; end
    for (int i = 0; i < 4; i++) if (t[i] == m) n++;
    ti = (n > 1) ? 1 : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin tal[i] = 0; tal_s[i] = 0; end
    m_ovf = 0;
    m_ovf_s = 0;
  endtask

  task automatic model_vote(input int idx);
    if (tal[idx] < 255) tal[idx]++; else m_ovf = 1;
    if (tal_s[idx] < 3) tal_s[idx]++; else m_ovf_s = 1;
  endtask

  task automatic check_results(input string tag);
    int w, ti;
    argmax(tal, w, ti);
    check({tag, "_winner"}, int'(win_a), w);
    check({tag, "_tie"}, int'(tie_a), ti);
    check({tag, "_overflow"}, int'(ovf_a), int'(m_ovf));
    argmax(tal_s, w, ti);
    check({tag, "_winner_s"}, int'(win_s), w);
    check({tag, "_tie_s"}, int'(tie_s), ti);
    check({tag, "_overflow_s"}, int'(ovf_s), int'(m_ovf_s));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_led"}, int'(led_a), 0);
    check({tag, "_vv"}, int'(vv_a), 0);
    check({tag, "_winner"}, int'(win_a), 0);
    check({tag, "_tie"}, int'(tie_a), 0);
    check({tag, "_overflow"}, int'(ovf_a), 0);
    check({tag, "_led_s"}, int'(led_s), 0);
    check({tag, "_tie_s"}, int'(tie_s), 0);
    check({tag, "_overflow_s"}, int'(ovf_s), 0);
  endtask

  // One press episode starting from IDLE; the vote lands DEB+1 cycles after the drive.
  task automatic press(input logic [3:0] pat, input int len, input int gap, input string tag);
    int s = cyc;
    mode = 1'b0;
    button = pat;
    if ($onehot(pat) && len >= DEB) begin
      exp_q.push_back('{at: s + 1 + DEB, idx: lowest(pat)});
      model_vote(lowest(pat));
    end
    repeat (len) tick();
    button = 4'b0000;
    repeat (gap) tick();
    check_results(tag);
  endtask

  task automatic display(input logic [3:0] pat, input string tag);
    int idx = lowest(pat);
    mode = 1'b1;
    button = pat;
    tick();
    check({tag, "_led"}, int'(led_a), (idx < 0) ? 0 : tal[idx]);
    check({tag, "_led_s"}, int'(led_s), (idx < 0) ? 0 : tal_s[idx]);
    mode = 1'b0;
    button = 4'b0000;
    tick();
    check({tag, "_led_off"}, int'(led_a), 0);
    tick();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_zero(tag);
    model_clear();
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  always @(negedge clock) begin
    if (vv_a || vv_s) begin
      check("vote_valid_pair", int'(vv_s), int'(vv_a));
      if (exp_q.size() == 0) begin
        check("unexpected_vote", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("vote_cycle", cyc, e.at);
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
      e = exp_q.pop_front();
      check("missed_vote", cyc, e.at);
    end
  end

  initial begin
    int s;
    logic [3:0] pat;
    int len;
    model_clear();
    tick();
    tick();
    check_zero("reset_state");
    reset = 1'b1;
    tick();
    tick();
    check_results("post_reset");

    press(4'b0001, 10, 3, "hold10");
    display(4'b0001, "disp_c0");
    press(4'b0001, 5, 3, "hold5");
    press(4'b0010, 200, 3, "hold200");
    press(4'b0001, 9, 3, "hold9");
    press(4'b0110, 50, 3, "multi");
    press(4'b0100, 10, 3, "c2");
    display(4'b0110, "disp_multi");
    display(4'b0000, "disp_none");
    for (int i = 0; i < 4; i++) press(4'b1000, 10, 2, "sat");

    do_reset("reset_mid");
    press(4'b0010, 10, 2, "tie_a");
    press(4'b0010, 10, 2, "tie_b");
    press(4'b0100, 10, 2, "tie_c");
    press(4'b0100, 10, 2, "tie_d");
    press(4'b0100, 12, 3, "untie");

    // Reset during debounce with the button still held: the press restarts from release.
    mode = 1'b0;
    button = 4'b0001;
    repeat (8) tick();
    #2;
    reset = 1'b0;
    #1;
    check_zero("reset_debounce");
    model_clear();
    tick();
    reset = 1'b1;
    s = cyc;
    exp_q.push_back('{at: s + 1 + DEB, idx: 0});
    model_vote(0);
    repeat (DEB) tick();
    button = 4'b0000;
    repeat (3) tick();
    check_results("after_reset_vote");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pat = 4'(1 << $urandom_range(0, 3));
        6, 7:             pat = 4'($urandom_range(1, 15));
        default:          pat = 4'b0000;
      endcase
      len = ($urandom_range(0, 3) == 0) ? DEB - 1 + $urandom_range(0, 1) : $urandom_range(1, 25);
      press(pat, len, $urandom_range(2, 4), "rand");
      if (n % 4 == 3) display(4'($urandom_range(0, 15)), "rand_disp");
    end

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
